// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory responder that turns CU strobes into single RAM accesses
// at the matrix effective address and returns read data through the MDR.
module dmem_ctrl #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int MAT_ROWS = 4,
    parameter int MAT_COLS = 4,
    localparam int RW = $clog2(MAT_ROWS),
    localparam int CW = $clog2(MAT_COLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dmem_read,
    input  logic              dmem_write,
    input  logic              mar_inc,
    input  logic              col_inc,
    input  logic              row_inc,
    input  logic              col_zero,
    input  logic              mar_load,
    input  logic [ADDR_W-1:0] mar_din,
    input  logic [DATA_W-1:0] wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mdr,
    output logic              rdata_valid,
    output logic              busy,
    output logic [RW-1:0]     row_idx,
    output logic [CW-1:0]     col_idx,
    output logic              mat_end,
    output logic              proto_err
);
    typedef enum logic [1:0] {IDLE, RD, RD_CAP, WR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, mar_q, mar_d, ea;
    logic [DATA_W-1:0] wdata_q, wdata_d, mdr_q, mdr_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic              rv_q, rv_d, end_q, end_d, err_q, err_d;
    logic              row_last, col_last;

    assign row_last = row_q == RW'(MAT_ROWS - 1);
    assign col_last = col_q == CW'(MAT_COLS - 1);
    // Uses pre-update indices so same-cycle increments do not affect this access.
    assign ea = mar_q + ADDR_W'(row_q) * ADDR_W'(MAT_COLS) + ADDR_W'(col_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mdr_d   = mdr_q;
        rv_d    = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (dmem_write) begin
                    addr_d  = ea;
                    wdata_d = wdata;
                    state_d = WR;
                    err_d   = err_q | dmem_read;
                end else if (dmem_read) begin
                    addr_d  = ea;
                    state_d = RD;
                end
            end
            RD:     state_d = RD_CAP;
            RD_CAP: begin
                mdr_d   = mem_rdata;
                rv_d    = 1'b1;
                state_d = IDLE;
            end
            WR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && (dmem_read || dmem_write))
            err_d = 1'b1;
        mar_d = mar_load ? mar_din : mar_inc ? mar_q + ADDR_W'(1) : mar_q;
        col_d = col_zero ? '0 : col_inc ? (col_last ? '0 : col_q + CW'(1)) : col_q;
        row_d = row_inc ? (row_last ? '0 : row_q + RW'(1)) : row_q;
        end_d = row_inc && row_last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            mdr_q   <= '0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
            mar_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mdr_q   <= mdr_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
            mar_q   <= mar_d;
            col_q   <= col_d;
            row_q   <= row_d;
            end_q   <= end_d;
        end
    end

    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_re      = state_q == RD;
    assign mem_we      = state_q == WR;
    assign busy        = state_q != IDLE;
    assign mdr         = mdr_q;
    assign rdata_valid = rv_q;
    assign row_idx     = row_q;
    assign col_idx     = col_q;
    assign mat_end     = end_q;
    assign proto_err   = err_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized scoreboard bench for dmem_ctrl against a behavioural model.
module tb_dmem_ctrl;
    localparam int R = 4;
    localparam int C = 4;

    logic        clk = 0, reset = 1;
    logic        dmem_read = 0, dmem_write = 0, mar_inc = 0, col_inc = 0;
    logic        row_inc = 0, col_zero = 0, mar_load = 0;
    logic [7:0]  mar_din = 0;
    logic [15:0] wdata = 0;
    logic [7:0]  mem_addr;
    logic        mem_re, mem_we, rdata_valid, busy, mat_end, proto_err;
    logic [15:0] mem_wdata, mdr;
    logic [15:0] mem_rdata = 0;
    logic [1:0]  row_idx, col_idx;

    dmem_ctrl dut (
        .clk(clk), .reset(reset), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .mar_inc(mar_inc), .col_inc(col_inc), .row_inc(row_inc), .col_zero(col_zero),
        .mar_load(mar_load), .mar_din(mar_din), .wdata(wdata), .mem_addr(mem_addr),
        .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mdr(mdr), .rdata_valid(rdata_valid), .busy(busy), .row_idx(row_idx),
        .col_idx(col_idx), .mat_end(mat_end), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // Synchronous RAM seen by the DUT
    logic [15:0] ram [256];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    typedef struct {bit we; logic [7:0] a; logic [15:0] d;} acc_t;
    acc_t        accq[$];
    logic [15:0] rdq[$];
    logic [15:0] ref_mem [256];
    logic [15:0] m_mdr = 0;
    int m_mar = 0, m_row = 0, m_col = 0, m_busy = 0, m_rdcnt = 0;
    bit m_proto = 0, m_end = 0, m_re = 0, m_we = 0, m_rv = 0, started = 0;
    int total = 0, bad = 0;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
        end
    endfunction

    // Reference model: access-level view of the controller
    always @(posedge clk) begin
        int ea;
        bit acc;
        if (reset) begin
            m_mar = 0; m_row = 0; m_col = 0; m_busy = 0; m_rdcnt = 0;
            m_proto = 0; m_end = 0; m_re = 0; m_we = 0; m_rv = 0; m_mdr = 0;
            accq.delete();
            rdq.delete();
        end else begin
            m_end = row_inc && m_row == R - 1;
            m_re = 0;
            m_we = 0;
            m_rv = m_rdcnt == 1;
            if (m_rv) m_mdr = rdq.pop_front();
            if (m_rdcnt > 0) m_rdcnt--;
            acc = (dmem_read || dmem_write) && m_busy == 0;
            if ((dmem_read || dmem_write) && m_busy != 0) m_proto = 1;
            if (dmem_read && dmem_write) m_proto = 1;
            if (m_busy > 0) m_busy--;
            ea = (m_mar + m_row * C + m_col) % 256;
            if (acc && dmem_write) begin
                accq.push_back('{1'b1, 8'(ea), wdata});
                ref_mem[ea] = wdata;
                m_busy = 1;
                m_we = 1;
            end else if (acc) begin
                accq.push_back('{1'b0, 8'(ea), 16'h0});
                rdq.push_back(ref_mem[ea]);
                m_busy = 2;
                m_rdcnt = 2;
                m_re = 1;
            end
            m_mar = mar_load ? int'(mar_din) : mar_inc ? (m_mar + 1) % 256 : m_mar;
            m_col = col_zero ? 0 : col_inc ? (m_col + 1) % C : m_col;
            m_row = row_inc ? (m_row + 1) % R : m_row;
        end
    end

    // Monitor
    always @(negedge clk) begin
        acc_t x;
        if (started) begin
            chk("mem_re", mem_re, m_re);
            chk("mem_we", mem_we, m_we);
            chk("re_we_overlap", mem_re & mem_we, 0);
            chk("busy", busy, m_busy != 0);
            chk("rdata_valid", rdata_valid, m_rv);
            chk("mdr", mdr, m_mdr);
            chk("row_idx", row_idx, m_row);
            chk("col_idx", col_idx, m_col);
            chk("mat_end", mat_end, m_end);
            chk("proto_err", proto_err, m_proto);
            if (mem_re || mem_we) begin
                if (accq.size() == 0) chk("unexpected_access", 1, 0);
                else begin
                    x = accq.pop_front();
                    chk("acc_kind", mem_we, x.we);
                    chk("acc_addr", mem_addr, x.a);
                    if (x.we) chk("acc_wdata", mem_wdata, x.d);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        {dmem_read, dmem_write, mar_inc, col_inc, row_inc, col_zero, mar_load, reset} = '0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            ram[i] = v;
            ref_mem[i] = v;
        end
        tick();
        started = 1;
        mar_din = 8'h10; mar_load = 1; tick();
        col_inc = 1; tick();
        col_inc = 1; tick();
        row_inc = 1; tick();
        wdata = 16'hBEEF; dmem_write = 1; tick();
        chk("wr_addr", mem_addr, 8'h16);
        chk("wr_data", mem_wdata, 16'hBEEF);
        ticks(2);
        chk("ram_16", ram[8'h16], 16'hBEEF);
        ram[8'h16] = 16'h1234;
        ref_mem[8'h16] = 16'h1234;
        dmem_read = 1; tick();
        chk("rd_re", mem_re, 1);
        chk("rd_addr", mem_addr, 8'h16);
        ticks(2);
        chk("rd_mdr", mdr, 16'h1234);
        chk("rd_valid", rdata_valid, 1);
        tick();
        reset = 1; tick();
        for (int i = 0; i < 4; i++) begin col_inc = 1; tick(); end
        for (int i = 0; i < 4; i++) begin row_inc = 1; tick(); end
        tick();
        col_inc = 1; tick();
        col_inc = 1; col_zero = 1; tick();
        chk("col_zero_wins", col_idx, 0);
        mar_din = 8'hFF; mar_load = 1; tick();
        mar_inc = 1; tick();
        dmem_read = 1; tick();
        chk("mar_wrap_addr", mem_addr, 8'h00);
        ticks(3);
        mar_din = 8'hFA; mar_load = 1; tick();
        for (int i = 0; i < 3; i++) begin row_inc = 1; col_inc = 1; tick(); end
        dmem_read = 1; tick();
        chk("ea_wrap_addr", mem_addr, 8'h09);
        ticks(3);
        dmem_read = 1; dmem_write = 1; wdata = 16'h5555; tick();
        chk("rw_clash_we", mem_we, 1);
        chk("rw_clash_err", proto_err, 1);
        ticks(2);
        dmem_read = 1; tick();
        dmem_read = 1; tick();
        ticks(3);
        chk("err_sticky", proto_err, 1);
        dmem_read = 1; tick();
        reset = 1; tick();
        tick();
        chk("rst_re", mem_re, 0);
        chk("rst_mdr", mdr, 0);
        chk("rst_err", proto_err, 0);
        for (int i = 0; i < 2000; i++) begin
            dmem_read  = $urandom_range(0, 99) < 25;
            dmem_write = $urandom_range(0, 99) < 15;
            mar_load   = $urandom_range(0, 99) < 5;
            mar_inc    = $urandom_range(0, 99) < 20;
            col_inc    = $urandom_range(0, 99) < 30;
            col_zero   = $urandom_range(0, 99) < 10;
            row_inc    = $urandom_range(0, 99) < 15;
            reset      = $urandom_range(0, 99) < 1;
            mar_din    = 8'($urandom);
            wdata      = 16'($urandom);
            tick();
        end
        ticks(4);
        chk("accq_empty", accq.size(), 0);
        chk("rdq_empty", rdq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory responder for the processor's control unit. Consumes the CU's single-cycle strobes (dmem_read, dmem_write, mar_inc, col_inc, row_inc, col_zero) and maintains the MAR and the row/column matrix indices. Computes the effective address and sequences one synchronous-RAM access per strobe. Returns read data through an MDR register with a valid pulse.

## Interface
- DATA_W, 16, data bus / memory word width
- ADDR_W, 8, memory address width
- MAT_ROWS, 4, matrix row count (row index wraps at MAT_ROWS-1)
- MAT_COLS, 4, matrix column count (column index wraps at MAT_COLS-1; also the row stride)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- dmem_read  in  1  CU read strobe, one cycle wide
- dmem_write  in  1  CU write strobe, one cycle wide
- mar_inc  in  1  increment MAR
- col_inc  in  1  increment column index
- row_inc  in  1  increment row index
- col_zero  in  1  clear column index
- mar_load  in  1  load MAR from mar_din
- mar_din  in  ADDR_W  MAR load value
- wdata  in  DATA_W  write data from datapath bus, sampled with dmem_write
- mem_addr  out  ADDR_W  RAM address
- mem_re  out  1  RAM read enable
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_re
- mdr  out  DATA_W  memory data register
- rdata_valid  out  1  one-cycle pulse: mdr just updated
- busy  out  1  access in progress
- row_idx  out  clog2(MAT_ROWS)  current row index
- col_idx  out  clog2(MAT_COLS)  current column index
- mat_end  out  1  one-cycle pulse on row wrap
- proto_err  out  1  sticky protocol-violation flag

## Operation
- Reset: every output and register is 0, and the FSM is in IDLE. Reset aborts any access in progress, so mem_re/mem_we are 0 in the cycle after reset is sampled.
- Effective address ea = (mar + row_idx*MAT_COLS + col_idx) mod 2^ADDR_W.
- FSM states: IDLE, RD, RD_CAP, WR.
  - IDLE + dmem_write: latch ea into mem_addr and wdata into mem_wdata, then go to WR.
  - IDLE + dmem_read (no dmem_write): latch ea into mem_addr, then go to RD.
  - RD: mem_re=1; go to RD_CAP.
  - RD_CAP: mdr <= mem_rdata, rdata_valid <= 1; go to IDLE.
  - WR: mem_we=1; go to IDLE.
- busy = (state != IDLE).
- Read and write in the same IDLE cycle: the write wins, the read is dropped, and proto_err is set.
- A dmem_read or dmem_write while busy is ignored and sets proto_err.
- proto_err is cleared only by reset.
- Index and MAR updates are allowed in any state. The access address is frozen at issue, so an in-flight access is unaffected.
- MAR update priority: mar_load over mar_inc. mar_inc wraps modulo 2^ADDR_W.
- Column update priority: col_zero over col_inc. col_inc at MAT_COLS-1 wraps to 0 and does not touch row_idx.
- row_inc at MAT_ROWS-1 wraps to 0 and pulses mat_end in the following cycle. Otherwise row_inc adds 1.
- The CU's row_inc and col_zero arrive together; both take effect in the same edge.
- mdr holds its value until the next completed read.

## Timing
- Read: dmem_read sampled at edge E0.
  - Cycle after E0: mem_re=1, mem_addr=ea.
  - Cycle after E1: RD_CAP.
  - Cycle after E2: mdr valid, rdata_valid=1, busy=0.
  - Strobe to data: 3 cycles.
- Write: dmem_write sampled at E0. In the cycle after E0, mem_we=1 with the latched addr/data; busy drops after E1. Strobe to RAM write: 1 cycle.
- Back-to-back: a new strobe is accepted at the first edge where busy=0. Minimum spacing is 3 cycles for reads and 2 for writes.
- ea uses index/MAR values as of the strobe cycle, before any same-cycle increment takes effect.
- mem_re and mem_we are never high together and never high for more than 1 cycle per access.

## Test plan
- Reset, then mar_load 0x10, col_inc x2, row_inc x1 (MAT_COLS=4), write strobe with wdata=0xBEEF -> mem_we=1 at addr 0x16 with mem_wdata=0xBEEF one cycle later; busy high for exactly 1 cycle.
- RAM preloaded with 0x1234 at 0x16, same indices, dmem_read -> mem_re at 0x16, then mdr=0x1234 and rdata_valid pulse 3 cycles after the strobe.
- col_inc x4 from 0 -> col_idx 0,1,2,3,0 with row_idx unchanged. row_inc x4 -> row_idx wraps to 0 and mat_end pulses exactly once. col_zero+col_inc in the same cycle -> col_idx=0.
- mar_load 0xFF then mar_inc -> mar=0x00. Read at row 3, col 3 with MAR 0xFA -> mem_addr=0x09 (mod 256).
- dmem_read+dmem_write in the same cycle -> write only, proto_err=1. A second read strobe one cycle after a read -> ignored, a single mem_re pulse, proto_err stays 1 until reset.
- Reset asserted during RD -> the next cycle has mem_re=0, mdr=0, no rdata_valid, and all indices and MAR are 0.
